if_stage: RTL and testbench

Instruction-fetch stage of the MIPS pipeline. It owns the program counter, drives the byte address into the instruction memory, and captures the returned word into the IF/ID pipeline register for decode. It applies stall and redirect requests from decode/hazard logic, injects bubbles on redirect, and stops fetching once the PC runs past the loaded program.

---
 rtl/if_stage_if.sv | 36 +++
 rtl/if_stage.sv | 116 +++++++++++
 tb/tb_if_stage.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_if
//  Description : Bundle of the fetch-stage signals. It covers the
//                redirect/stall controls coming from decode and hazard logic,
//                the instruction-memory address/data pair, and the IF/ID
//                register outputs.
//                - slave  : the view used by if_stage
//                - master : the view used by the surrounding pipeline/memory
//  Revision    : 1.0  initial release
// ============================================================================
interface if_stage_if;
   logic        stall;          // hold PC and IF/ID
   logic        branch_taken;   // redirect to branch_target
   logic [31:0] branch_target;
   logic        jump;           // redirect to jump_target
   logic [31:0] jump_target;
   logic [31:0] inst_adr;       // byte address to instruction memory
   logic [31:0] inst_in;        // word returned for inst_adr
   logic [31:0] pc;             // current program counter
   logic [31:0] if_id_inst;     // instruction latched for decode
   logic [31:0] if_id_pc4;      // PC+4 of the latched instruction
   logic        if_id_valid;    // latched instruction is not a bubble
   logic        fetch_done;     // fetch halted past the program end

   modport slave (
      input  stall, branch_taken, branch_target, jump, jump_target, inst_in,
      output inst_adr, pc, if_id_inst, if_id_pc4, if_id_valid, fetch_done
   );

   modport master (
      output stall, branch_taken, branch_target, jump, jump_target, inst_in,
      input  inst_adr, pc, if_id_inst, if_id_pc4, if_id_valid, fetch_done
   );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : MIPS instruction-fetch stage. Owns the PC, addresses the
//                combinational instruction memory and captures the returned
//                word into the IF/ID register. Stall holds everything; a
//                taken branch (priority) or jump redirects the PC and
//                injects one bubble. Fetch halts once the PC reaches
//                4*INST bytes.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                bus  - if_stage_if.slave (controls, memory, IF/ID outputs)
//  Revision    : 1.0  initial release
// ============================================================================
module if_stage #(
   parameter int unsigned INST     = 1,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input logic        clk,
   input logic        rst,
   if_stage_if.slave  bus
);

   // The fetch limit is kept at 34 bits so that 4*INST cannot wrap.
   localparam logic [33:0] c_limit = {INST[31:0], 2'b00};

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic [31:0] r_pc4;
   logic        r_valid;

   state_t      w_next_state;
   logic [31:0] w_next_pc;
   logic [31:0] w_next_inst;
   logic [31:0] w_next_pc4;
   logic        w_next_valid;
   logic [31:0] w_pc_plus4;

   assign w_pc_plus4 = r_pc + 32'd4;

   // ------------------------------------------------------------------------
   // State / pipeline registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RUN;
         r_pc    <= RESET_PC;
         r_inst  <= 32'h0;
         r_pc4   <= 32'h0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_pc    <= w_next_pc;
         r_inst  <= w_next_inst;
         r_pc4   <= w_next_pc4;
         r_valid <= w_next_valid;
      end
   end

   // ------------------------------------------------------------------------
   // Next-PC selection, IF/ID load and RUN/HALT transition
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_next_pc    = r_pc;
      w_next_inst  = r_inst;
      w_next_pc4   = r_pc4;
      w_next_valid = r_valid;

      // Stall wins over redirects: decode re-presents the redirect afterwards.
      if (!bus.stall) begin
         if (bus.branch_taken) begin
            w_next_pc    = {bus.branch_target[31:2], 2'b00};
            w_next_inst  = 32'h0;
            w_next_pc4   = 32'h0;
            w_next_valid = 1'b0;
         end else if (bus.jump) begin
            w_next_pc    = {bus.jump_target[31:2], 2'b00};
            w_next_inst  = 32'h0;
            w_next_pc4   = 32'h0;
            w_next_valid = 1'b0;
         end else if (r_state == RUN) begin
            w_next_pc    = w_pc_plus4;
            w_next_inst  = bus.inst_in;
            w_next_pc4   = w_pc_plus4;
            w_next_valid = 1'b1;
         end else begin
            // HALT: memory data is out of range, so feed NOP bubbles.
            w_next_inst  = 32'h0;
            w_next_pc4   = 32'h0;
            w_next_valid = 1'b0;
         end

         // Redirects can move in or out of HALT directly.
         w_next_state = ({2'b00, w_next_pc} >= c_limit) ? HALT : RUN;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.inst_adr    = r_pc;
   assign bus.pc          = r_pc;
   assign bus.if_id_inst  = r_inst;
   assign bus.if_id_pc4   = r_pc4;
   assign bus.if_id_valid = r_valid;
   assign bus.fetch_done  = (r_state == HALT);

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Scoreboard bench for if_stage with INST=4. Each stimulus
//                step queues the hand-computed state expected after the next
//                rising edge. A monitor pops and compares one entry on every
//                falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_stage;

   localparam logic [31:0] c_reset_pc = 32'h0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] pc4;
      logic        valid;
      logic        done;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] mem [4];
   exp_t        q[$];
   int          n_pass;
   int          n_total;

   if_stage_if bus ();

   if_stage #(
      .INST     (4),
      .RESET_PC (c_reset_pc)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Combinational instruction memory; out-of-range reads return junk that
   // must never reach IF/ID.
   assign bus.inst_in = (bus.inst_adr < 32'd16) ? mem[bus.inst_adr[3:2]]
                                                : 32'hDEAD_BEEF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%h required=%h @%0t", name, act, exp, $time);
   endtask

   // Monitor: one expected entry per rising edge, checked mid-cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("pc",          bus.pc,                 e.pc);
         chk("inst_adr",    bus.inst_adr,           e.pc);
         chk("if_id_inst",  bus.if_id_inst,         e.inst);
         chk("if_id_pc4",   bus.if_id_pc4,          e.pc4);
         chk("if_id_valid", {31'h0, bus.if_id_valid}, {31'h0, e.valid});
         chk("fetch_done",  {31'h0, bus.fetch_done},  {31'h0, e.done});
      end
   end

   task automatic check_reset_values(input string tag);
      chk({tag, "_pc"},    bus.pc,         c_reset_pc);
      chk({tag, "_inst"},  bus.if_id_inst, 32'h0);
      chk({tag, "_pc4"},   bus.if_id_pc4,  32'h0);
      chk({tag, "_valid"}, {31'h0, bus.if_id_valid}, 32'h0);
      chk({tag, "_done"},  {31'h0, bus.fetch_done},  32'h0);
   endtask

   task automatic idle_inputs();
      bus.stall         = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 32'h0;
      bus.jump          = 1'b0;
      bus.jump_target   = 32'h0;
   endtask

   // Reset, released just after a rising edge so the next edge is the first fetch.
   task automatic do_reset();
      @(negedge clk);
      #1;
      rst = 1'b1;
      idle_inputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_reset_values("reset");
   endtask

   task automatic step(input logic s, input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt,
                       input logic [31:0] epc, input logic [31:0] einst,
                       input logic [31:0] epc4, input logic ev, input logic ed);
      exp_t e;
      @(negedge clk);
      #1;
      bus.stall         = s;
      bus.branch_taken  = br;
      bus.branch_target = bt;
      bus.jump          = jp;
      bus.jump_target   = jt;
      e.pc = epc; e.inst = einst; e.pc4 = epc4; e.valid = ev; e.done = ed;
      q.push_back(e);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      mem[0] = 32'h1111_0000;
      mem[1] = 32'h2222_0001;
      mem[2] = 32'h3333_0002;
      mem[3] = 32'h4444_0003;
      rst = 1'b1;
      idle_inputs();

      // Straight-line fetch to the end of the program, then halt bubbles.
      do_reset();
      step(0,0,0,0,0, 32'd4,  mem[0], 32'd4,  1, 0);
      step(0,0,0,0,0, 32'd8,  mem[1], 32'd8,  1, 0);
      step(0,0,0,0,0, 32'd12, mem[2], 32'd12, 1, 0);
      step(0,0,0,0,0, 32'd16, mem[3], 32'd16, 1, 1);
      step(0,0,0,0,0, 32'd16, 32'h0,  32'h0,  0, 1);
      step(0,0,0,0,0, 32'd16, 32'h0,  32'h0,  0, 1);

      // Two-cycle stall.
      do_reset();
      step(0,0,0,0,0, 32'd4,  mem[0], 32'd4,  1, 0);
      step(0,0,0,0,0, 32'd8,  mem[1], 32'd8,  1, 0);
      step(1,0,0,0,0, 32'd8,  mem[1], 32'd8,  1, 0);
      step(1,0,0,0,0, 32'd8,  mem[1], 32'd8,  1, 0);
      step(0,0,0,0,0, 32'd12, mem[2], 32'd12, 1, 0);

      // Misaligned branch target, stall+branch, branch vs jump, HALT entry/exit.
      do_reset();
      step(0,0,0,0,0, 32'd4,  mem[0], 32'd4,  1, 0);
      step(0,0,0,0,0, 32'd8,  mem[1], 32'd8,  1, 0);
      step(0,1,32'h6,0,0, 32'd4, 32'h0, 32'h0, 0, 0);
      step(0,0,0,0,0, 32'd8,  mem[1], 32'd8,  1, 0);
      step(1,1,32'h0,0,0, 32'd8, mem[1], 32'd8, 1, 0);
      step(0,1,32'h0,0,0, 32'd0, 32'h0, 32'h0, 0, 0);
      step(0,0,0,0,0, 32'd4,  mem[0], 32'd4,  1, 0);
      step(0,1,32'hC,1,32'h100, 32'd12, 32'h0, 32'h0, 0, 0);
      step(0,0,0,1,32'h100, 32'h100, 32'h0, 32'h0, 0, 1);
      step(0,0,0,0,0, 32'h100, 32'h0, 32'h0, 0, 1);
      step(0,1,32'h0,0,0, 32'd0, 32'h0, 32'h0, 0, 0);
      step(0,0,0,0,0, 32'd4,  mem[0], 32'd4,  1, 0);
      step(0,0,0,1,32'h100, 32'h100, 32'h0, 32'h0, 0, 1);

      // Asynchronous reset between edges, observed before the next edge.
      @(negedge clk);
      idle_inputs();
      #2;
      rst = 1'b1;
      #1;
      check_reset_values("async_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(0,0,0,0,0, 32'd4,  mem[0], 32'd4,  1, 0);

      @(negedge clk);
      #1;
      chk("queue_drained", q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
